// File: rtl/gametank_bus_pkg.sv
// Shared types, constants and the packed-parameter slicing helper for the GameTank bus control unit.
package gametank_bus_pkg;

  typedef enum logic {ST_IDLE, ST_WAIT} bcu_state_e;

  localparam int WAIT_W   = 3;
  localparam int PACK_MAX = 256;

  localparam logic [63:0] DEF_REG_BASE = {16'h8000, 16'h4000, 16'h2000, 16'h0000};
  localparam logic [63:0] DEF_REG_MASK = {16'h8000, 16'hC000, 16'hE000, 16'hE000};
  localparam logic [11:0] DEF_REG_WAIT = {3'd1, 3'd0, 3'd2, 3'd0};

  // Field idx of width w from a packed parameter vector, zero-extended to 32 bits.
  function automatic logic [31:0] pack_field(input logic [PACK_MAX-1:0] vec,
                                             input int idx, input int w);
    logic [PACK_MAX-1:0] sh;
    sh = vec >> (idx * w);
    for (int b = 0; b < 32; b++) pack_field[b] = (b < w) ? sh[b] : 1'b0;
  endfunction

endpackage

// File: rtl/bcu_region_decoder.sv
// Combinational priority decoder: bank register first, then lowest-index matching region.
module bcu_region_decoder
  import gametank_bus_pkg::*;
#(
  parameter int                        ADDR_W    = 16,
  parameter int                        N_REG     = 4,
  parameter int                        IDX_W     = (N_REG > 1) ? $clog2(N_REG) : 1,
  parameter logic [N_REG*ADDR_W-1:0]   REG_BASE  = DEF_REG_BASE,
  parameter logic [N_REG*ADDR_W-1:0]   REG_MASK  = DEF_REG_MASK,
  parameter logic [N_REG*WAIT_W-1:0]   REG_WAIT  = DEF_REG_WAIT,
  parameter logic [ADDR_W-1:0]         BANK_ADDR = 16'h2005
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_REG-1:0]  hit_oh,
  output logic [IDX_W-1:0]  hit_idx,
  output logic              bank_hit,
  output logic              miss,
  output logic [WAIT_W-1:0] wait_n
);

  logic [N_REG-1:0]  match;
  logic [WAIT_W-1:0] wait_tab [N_REG];
  logic              found;

  for (genvar r = 0; r < N_REG; r++) begin : g_reg
    localparam logic [ADDR_W-1:0] BASE_R = ADDR_W'(pack_field(PACK_MAX'(REG_BASE), r, ADDR_W));
    localparam logic [ADDR_W-1:0] MASK_R = ADDR_W'(pack_field(PACK_MAX'(REG_MASK), r, ADDR_W));
    assign match[r]    = ((addr & MASK_R) == BASE_R);
    assign wait_tab[r] = WAIT_W'(pack_field(PACK_MAX'(REG_WAIT), r, WAIT_W));
  end

  always_comb begin
    bank_hit = (addr == BANK_ADDR);
    hit_oh   = '0;
    hit_idx  = '0;
    wait_n   = '0;
    found    = 1'b0;
    for (int r = 0; r < N_REG; r++) begin
      if (!found && match[r]) begin
        found      = 1'b1;
        hit_oh[r]  = 1'b1;
        hit_idx    = IDX_W'(r);
        wait_n     = wait_tab[r];
      end
    end
    // The bank register shadows any region it overlaps.
    if (bank_hit) begin
      hit_oh = '0;
      wait_n = '0;
    end
    miss = !bank_hit && !found;
  end

endmodule

// File: rtl/gametank_bcu.sv
// Bus control unit: region decode, wait-state handshake, read mux with open-bus latch, ROM bank register.
module gametank_bcu
  import gametank_bus_pkg::*;
#(
  parameter int                      ADDR_W       = 16,
  parameter int                      DATA_W       = 8,
  parameter int                      N_REG        = 4,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE     = DEF_REG_BASE,
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK     = DEF_REG_MASK,
  parameter logic [N_REG*WAIT_W-1:0] REG_WAIT     = DEF_REG_WAIT,
  parameter int                      BANK_W       = 4,
  parameter logic [ADDR_W-1:0]       BANK_ADDR    = 16'h2005,
  parameter logic [DATA_W-1:0]       OPEN_BUS_RST = 8'hFF
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_rdy,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic [N_REG-1:0]        dev_ce,
  output logic                    dev_rnw,
  output logic                    dev_wr,
  output logic [DATA_W-1:0]       dev_wdata,
  input  logic [N_REG*DATA_W-1:0] dev_rdata,
  output logic [BANK_W-1:0]       bank,
  output logic                    bus_miss
);

  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

  logic [N_REG-1:0]  hit_oh;
  logic [IDX_W-1:0]  hit_idx;
  logic              bank_hit, miss;
  logic [WAIT_W-1:0] wait_n;

  bcu_region_decoder #(
    .ADDR_W(ADDR_W), .N_REG(N_REG), .IDX_W(IDX_W),
    .REG_BASE(REG_BASE), .REG_MASK(REG_MASK), .REG_WAIT(REG_WAIT),
    .BANK_ADDR(BANK_ADDR)
  ) u_dec (
    .addr(cpu_addr), .hit_oh(hit_oh), .hit_idx(hit_idx),
    .bank_hit(bank_hit), .miss(miss), .wait_n(wait_n)
  );

  bcu_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              done, req, is_rd, rd_take;
  logic [DATA_W-1:0] ob_q, rd_slice;

  assign req   = cpu_rd | cpu_wr;
  assign is_rd = cpu_rd & ~cpu_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (wait_n == '0) done = 1'b1;
          else begin
            cnt_d   = wait_n - 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping the request abandons the access without side effects.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) done = 1'b0;
  end

  assign cpu_rdy   = done;
  assign dev_ce    = (req && !reset) ? hit_oh : '0;
  assign dev_rnw   = ~cpu_wr;
  assign dev_wdata = cpu_wdata;
  assign dev_wr    = done & cpu_wr & (|hit_oh);

  assign rd_slice  = dev_rdata[hit_idx*DATA_W +: DATA_W];
  assign rd_take   = done & is_rd & (|hit_oh);
  assign cpu_rdata = rd_take ? rd_slice : ob_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bank     <= '0;
      ob_q     <= OPEN_BUS_RST;
      bus_miss <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_miss <= done & miss;
      if (rd_take) ob_q <= rd_slice;
      if (done && cpu_wr && bank_hit) bank <= cpu_wdata[BANK_W-1:0];
    end
  end

endmodule

// File: tb/tb_gametank_bcu.sv
// Scoreboarded bench for gametank_bcu with region 2 narrowed to 4000h-4FFFh so 6000h is unmapped.
module tb_gametank_bcu;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic [7:0]  cpu_rdata;
  logic [3:0]  dev_ce;
  logic        dev_rnw, dev_wr;
  logic [7:0]  dev_wdata;
  logic [31:0] dev_rdata;
  logic [3:0]  bank;
  logic        bus_miss;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         lat;
    logic [3:0] ce;
    logic       rd_chk;
    logic [7:0] rdata;
    logic       wr;
  } exp_t;

  exp_t sb_q[$];

  gametank_bcu #(
    .REG_MASK({16'h8000, 16'hF000, 16'hE000, 16'hE000})
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dev_ce(dev_ce), .dev_rnw(dev_rnw), .dev_wr(dev_wr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .bank(bank), .bus_miss(bus_miss)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge sys_clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // Drives one access, then waits for cpu_rdy and scores it against the queued expectation.
  task automatic access(input string tag, input logic [15:0] a, input logic rd, input logic wr,
                        input logic [7:0] wd, input int lat, input logic [3:0] ce,
                        input logic rd_chk, input logic [7:0] rdata, input logic exp_wr);
    exp_t e;
    int   cyc;
    bit   got_rdy;
    sb_q.push_back('{lat, ce, rd_chk, rdata, exp_wr});
    @(posedge sys_clk); #1;
    cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
    got_rdy = 1'b0;
    cyc = 0;
    @(negedge sys_clk);
    chk({tag, "_ce"}, {28'd0, dev_ce}, {28'd0, ce});
    chk({tag, "_rnw"}, {31'd0, dev_rnw}, {31'd0, ~wr});
    while (cyc < 12) begin
      if (cpu_rdy) begin
        got_rdy = 1'b1;
        break;
      end
      chk({tag, "_wr_early"}, {31'd0, dev_wr}, 32'd0);
      cyc++;
      @(negedge sys_clk);
    end
    e = sb_q.pop_front();
    chk({tag, "_rdy_seen"}, {31'd0, got_rdy}, 32'd1);
    chk({tag, "_lat"}, cyc, e.lat);
    chk({tag, "_wr"}, {31'd0, dev_wr}, {31'd0, e.wr});
    if (wr) chk({tag, "_wdata"}, {24'd0, dev_wdata}, {24'd0, wd});
    if (e.rd_chk) chk({tag, "_rdata"}, {24'd0, cpu_rdata}, {24'd0, e.rdata});
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 16'h0000; cpu_rd = 1'b1; cpu_wr = 1'b0;
    cpu_wdata = 8'h00; dev_rdata = 32'h0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_rdy_forced", {31'd0, cpu_rdy}, 32'd0);
    chk("rst_ce_forced", {28'd0, dev_ce}, 32'd0);
    @(posedge sys_clk); #1;
    reset = 1'b0; cpu_rd = 1'b0;
    @(negedge sys_clk);
    chk("rst_bank", {28'd0, bank}, 32'd0);
    chk("rst_miss", {31'd0, bus_miss}, 32'd0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'hFF);

    // Region 3, one wait state.
    dev_rdata = 32'hA9_00_00_00;
    access("rd8123", 16'h8123, 1, 0, 8'h00, 1, 4'b1000, 1, 8'hA9, 0);
    // Region 1, two wait states, write strobe only in the last cycle.
    access("wr2010", 16'h2010, 0, 1, 8'h55, 2, 4'b0010, 0, 8'h00, 1);
    // Bank register write shadows region 1.
    access("wrbank", 16'h2005, 0, 1, 8'h3C, 0, 4'b0000, 0, 8'h00, 0);
    idle();
    @(negedge sys_clk);
    chk("bank_c", {28'd0, bank}, 32'hC);
    chk("bank_nowr", {31'd0, dev_wr}, 32'd0);

    // Region 3 read then back-to-back unmapped read returns the latched value.
    dev_rdata = 32'h42_11_22_33;
    access("rd9000", 16'h9000, 1, 0, 8'h00, 1, 4'b1000, 1, 8'h42, 0);
    access("rdmiss", 16'h6000, 1, 0, 8'h00, 0, 4'b0000, 1, 8'h42, 0);
    idle();
    @(negedge sys_clk);
    chk("miss_pulse", {31'd0, bus_miss}, 32'd1);
    @(negedge sys_clk);
    chk("miss_clear", {31'd0, bus_miss}, 32'd0);

    access("rd4000", 16'h4000, 1, 0, 8'h00, 0, 4'b0100, 1, 8'h11, 0);
    access("rd1000", 16'h1000, 1, 0, 8'h00, 0, 4'b0001, 1, 8'h33, 0);
    access("rdbank", 16'h2005, 1, 0, 8'h00, 0, 4'b0000, 1, 8'h33, 0);
    // Write wins over read when both are asserted.
    access("rdwr", 16'h0010, 1, 1, 8'h99, 0, 4'b0001, 0, 8'h00, 1);
    idle();

    // Reset in the middle of a two-wait write.
    @(posedge sys_clk); #1;
    cpu_addr = 16'h2010; cpu_wr = 1'b1; cpu_wdata = 8'hAA;
    @(negedge sys_clk);
    chk("rstw_rdy0", {31'd0, cpu_rdy}, 32'd0);
    @(posedge sys_clk); #1;
    reset = 1'b1;
    @(negedge sys_clk);
    chk("rstw_wr", {31'd0, dev_wr}, 32'd0);
    chk("rstw_ce", {28'd0, dev_ce}, 32'd0);
    @(posedge sys_clk); #1;
    reset = 1'b0; cpu_wr = 1'b0;
    @(negedge sys_clk);
    chk("rstw_bank", {28'd0, bank}, 32'd0);
    chk("rstw_rdata", {24'd0, cpu_rdata}, 32'hFF);
    chk("rstw_nowr", {31'd0, dev_wr}, 32'd0);
    dev_rdata = 32'hEE_00_00_77;
    access("rstw_idle", 16'h0000, 1, 0, 8'h00, 0, 4'b0001, 1, 8'h77, 0);
    idle();

    // Abort a one-wait read of 8000h by dropping the request.
    @(posedge sys_clk); #1;
    cpu_addr = 16'h8000; cpu_rd = 1'b1;
    @(negedge sys_clk);
    chk("abort_rdy0", {31'd0, cpu_rdy}, 32'd0);
    @(posedge sys_clk); #1;
    cpu_rd = 1'b0;
    @(negedge sys_clk);
    chk("abort_latch", {24'd0, cpu_rdata}, 32'h77);
    chk("abort_ce", {28'd0, dev_ce}, 32'd0);
    dev_rdata = 32'hEE_00_00_5A;
    access("abort_next", 16'h0000, 1, 0, 8'h00, 0, 4'b0001, 1, 8'h5A, 0);
    idle();
    @(negedge sys_clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
